ysyx_22050243_data_mem: RTL and testbench



---
 rtl/ysyx_22050243_data_mem_if.sv | 31 +++
 rtl/ysyx_22050243_data_mem.sv | 188 ++++++++++++++++++
 tb/tb_ysyx_22050243_data_mem.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050243_data_mem_if.sv
// Request/response bus between the LSU (master) and the data memory (slave).
// One request and one response channel, each with its own valid/ready pair.
interface ysyx_22050243_data_mem_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_wen;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [DATA_WIDTH/8-1:0] req_wmask;
    logic [1:0]              req_size;
    logic                    req_unsigned;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [DATA_WIDTH-1:0]   resp_rdata;
    logic                    resp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, req_size, req_unsigned,
        output resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, req_size, req_unsigned,
        input  resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/ysyx_22050243_data_mem.sv
// Single-port data memory with a one-outstanding valid/ready interface and a
// fixed extra response latency; the access itself happens at acceptance.
module ysyx_22050243_data_mem #(
    parameter int                    DATA_WIDTH = 64,
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    DEPTH      = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(64'h8000_0000),
    parameter int                    LATENCY    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    ysyx_22050243_data_mem_if.slave  bus
);
    localparam int NB   = DATA_WIDTH / 8;
    localparam int OFFW = $clog2(NB);
    localparam int IDXW = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(DEPTH * NB);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [3:0]            r_cnt;
    logic                  r_req_ready;
    logic                  r_resp_valid;
    logic                  r_resp_err;
    logic [DATA_WIDTH-1:0] r_resp_rdata;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_rel_addr;
    logic                  w_in_range;
    logic [OFFW-1:0]       w_off;
    logic [IDXW-1:0]       w_idx;
    logic [DATA_WIDTH-1:0] w_word;
    logic [DATA_WIDTH-1:0] w_raw;
    logic [1:0]            w_size_eff;
    logic [OFFW-1:0]       w_align_mask;
    logic                  w_err;
    int                    w_keep_bits;
    logic                  w_sign;
    logic [DATA_WIDTH-1:0] w_load;
    logic                  w_req_ready_d;
    logic                  w_resp_valid_d;
    logic                  w_resp_err_d;
    logic [DATA_WIDTH-1:0] w_resp_rdata_d;

    assign w_accept   = !rst && (r_state == ST_IDLE) && r_req_ready && bus.req_valid;
    assign w_rel_addr = bus.req_addr - BASE_ADDR;
    assign w_in_range = (bus.req_addr >= BASE_ADDR) && (w_rel_addr < MEM_BYTES);
    assign w_off      = bus.req_addr[OFFW-1:0];
    assign w_idx      = w_rel_addr[OFFW +: IDXW];
    assign w_word     = r_mem[w_idx];
    assign w_raw      = w_word >> {w_off, 3'b000};
    assign w_err      = !w_in_range || ((w_off & w_align_mask) != '0);

    // Effective access size (clamped to the word) and the offset bits it must leave clear.
    always_comb begin
        if (int'(bus.req_size) > OFFW) begin
            w_size_eff = 2'(OFFW);
        end else begin
            w_size_eff = bus.req_size;
        end
        w_align_mask = '0;
        for (int i = 0; i < OFFW; i++) begin
            if (i < int'(w_size_eff)) begin
                w_align_mask[i] = 1'b1;
            end else begin
                w_align_mask[i] = 1'b0;
            end
        end
    end

    // Load formatting: keep the low effective-size bytes, then zero- or sign-extend.
    always_comb begin
        w_keep_bits = 8 << w_size_eff;
        w_sign      = 1'b0;
        w_load      = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i == w_keep_bits - 1) begin
                w_sign = w_raw[i] & ~bus.req_unsigned;
            end else begin
                w_sign = w_sign;
            end
        end
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i < w_keep_bits) begin
                w_load[i] = w_raw[i];
            end else begin
                w_load[i] = w_sign;
            end
        end
    end

    // State register and wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_cnt <= 4'(LATENCY);
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = (LATENCY > 0) ? ST_WAIT : ST_RESP;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_next_state = ST_RESP;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_RESP;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered handshake and response outputs.
    always_comb begin
        w_req_ready_d  = (w_next_state == ST_IDLE);
        w_resp_valid_d = (w_next_state == ST_RESP);
        if (w_accept) begin
            w_resp_err_d   = w_err;
            w_resp_rdata_d = (w_err || bus.req_wen) ? '0 : w_load;
        end else begin
            w_resp_err_d   = r_resp_err;
            w_resp_rdata_d = r_resp_rdata;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_req_ready  <= w_req_ready_d;
            r_resp_valid <= w_resp_valid_d;
            r_resp_err   <= w_resp_err_d;
            r_resp_rdata <= w_resp_rdata_d;
        end
    end

    // Byte-masked store, committed at acceptance; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_accept && bus.req_wen && !w_err) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.req_wmask[i]) begin
                    r_mem[w_idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_rdata = r_resp_rdata;
endmodule

// File: tb/tb_ysyx_22050243_data_mem.sv
// Bench for ysyx_22050243_data_mem: directed scenarios on a LATENCY=2 and a
// LATENCY=0 instance plus randomized traffic against a byte-array memory model.
module tb_ysyx_22050243_data_mem;
    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam logic [63:0] MEMB = 64'd32768;
    localparam logic [63:0] REG  = 64'h8000_1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int          sel = 0;
    logic        t_valid = 1'b0;
    logic        t_wen = 1'b0;
    logic [63:0] t_addr = 64'd0;
    logic [63:0] t_wdata = 64'd0;
    logic [7:0]  t_wmask = 8'd0;
    logic [1:0]  t_size = 2'd0;
    logic        t_uns = 1'b0;
    logic        t_resp_ready = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    ysyx_22050243_data_mem_if #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) bus2 ();
    ysyx_22050243_data_mem_if #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) bus0 ();

    assign bus2.req_valid    = t_valid & (sel == 0);
    assign bus0.req_valid    = t_valid & (sel == 1);
    assign bus2.req_wen      = t_wen;
    assign bus0.req_wen      = t_wen;
    assign bus2.req_addr     = t_addr;
    assign bus0.req_addr     = t_addr;
    assign bus2.req_wdata    = t_wdata;
    assign bus0.req_wdata    = t_wdata;
    assign bus2.req_wmask    = t_wmask;
    assign bus0.req_wmask    = t_wmask;
    assign bus2.req_size     = t_size;
    assign bus0.req_size     = t_size;
    assign bus2.req_unsigned = t_uns;
    assign bus0.req_unsigned = t_uns;
    assign bus2.resp_ready   = t_resp_ready;
    assign bus0.resp_ready   = t_resp_ready;

    logic        o_req_ready, o_resp_valid, o_resp_err;
    logic [63:0] o_resp_rdata;
    assign o_req_ready  = (sel == 1) ? bus0.req_ready  : bus2.req_ready;
    assign o_resp_valid = (sel == 1) ? bus0.resp_valid : bus2.resp_valid;
    assign o_resp_err   = (sel == 1) ? bus0.resp_err   : bus2.resp_err;
    assign o_resp_rdata = (sel == 1) ? bus0.resp_rdata : bus2.resp_rdata;

    ysyx_22050243_data_mem #(.DATA_WIDTH(64), .ADDR_WIDTH(64), .DEPTH(4096),
        .BASE_ADDR(64'h8000_0000), .LATENCY(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
    ysyx_22050243_data_mem #(.DATA_WIDTH(64), .ADDR_WIDTH(64), .DEPTH(4096),
        .BASE_ADDR(64'h8000_0000), .LATENCY(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

    // Byte-addressed reference memory (offset from BASE).
    logic [7:0] mdl [32768];

    function automatic void model_txn(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                                      input logic [7:0] wmask, input logic [1:0] size, input logic uns,
                                      output logic err, output logic [63:0] rdata);
        logic [63:0] esz = 64'd1 << size;
        logic [63:0] a;
        logic [63:0] v = 64'd0;
        err   = 1'b0;
        rdata = 64'd0;
        if (addr < BASE || addr >= BASE + MEMB || (addr % esz) != 64'd0) begin
            err = 1'b1;
        end else begin
            a = addr - BASE;
            if (wen) begin
                for (int i = 0; i < 8; i++)
                    if (wmask[i]) mdl[int'((a & ~64'd7) + 64'(i))] = wdata[8*i +: 8];
            end else begin
                for (int k = 0; k < int'(esz); k++)
                    v = v | ({56'd0, mdl[int'(a) + k]} << (8 * k));
                if (!uns && esz < 64'd8 && v[8*int'(esz)-1]) v = v | (~64'd0 << (8 * int'(esz)));
                rdata = v;
            end
        end
    endfunction

    task automatic do_txn(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [7:0] wmask, input logic [1:0] size, input logic uns,
                          output logic [63:0] rdata, output logic err, output int lat);
        int guard = 0;
        rdata = 64'd0;
        err   = 1'b1;
        lat   = -1;
        @(negedge clk);
        t_wen = wen; t_addr = addr; t_wdata = wdata; t_wmask = wmask; t_size = size; t_uns = uns;
        t_resp_ready = 1'b1;
        t_valid = 1'b1;
        while (!o_req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!o_req_ready) begin
            n_checks++;
            $display("FAIL accept_timeout addr=%h req_ready=%b required=1", addr, o_req_ready);
            t_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        t_valid = 1'b0;
        lat = 1;
        while (!o_resp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!o_resp_valid) begin
            n_checks++;
            $display("FAIL resp_timeout addr=%h resp_valid=%b required=1", addr, o_resp_valid);
            lat = -1;
            return;
        end
        rdata = o_resp_rdata;
        err   = o_resp_err;
        @(posedge clk);
    endtask

    task automatic test_reset();
        int guard = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus2.req_ready, bus2.resp_valid, bus2.resp_err} !== 3'b000 || bus2.resp_rdata !== 64'd0)
            $display("FAIL reset_lat2 got rdy/vld/err=%b%b%b rdata=%h required 000/0",
                     bus2.req_ready, bus2.resp_valid, bus2.resp_err, bus2.resp_rdata);
        else n_pass++;
        n_checks++;
        if ({bus0.req_ready, bus0.resp_valid, bus0.resp_err} !== 3'b000 || bus0.resp_rdata !== 64'd0)
            $display("FAIL reset_lat0 got rdy/vld/err=%b%b%b rdata=%h required 000/0",
                     bus0.req_ready, bus0.resp_valid, bus0.resp_err, bus0.resp_rdata);
        else n_pass++;
        rst = 1'b0;
        while (!(bus2.req_ready && bus0.req_ready) && guard < 3) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (bus2.req_ready !== 1'b1 || bus0.req_ready !== 1'b1 || bus2.resp_valid !== 1'b0)
            $display("FAIL reset_release got rdy2=%b rdy0=%b vld2=%b required 1 1 0",
                     bus2.req_ready, bus0.req_ready, bus2.resp_valid);
        else n_pass++;
    endtask

    task automatic test_load_store();
        logic [63:0] rd;
        logic er;
        int lat;
        sel = 0;
        do_txn(1'b1, 64'h8000_0008, 64'h1122334455667788, 8'hFF, 2'd3, 1'b0, rd, er, lat);
        n_checks++;
        if (er !== 1'b0 || rd !== 64'd0 || lat != 3)
            $display("FAIL store_full got err=%b rdata=%h lat=%0d required 0 0 3", er, rd, lat);
        else n_pass++;
        do_txn(1'b0, 64'h8000_0008, 64'd0, 8'h00, 2'd3, 1'b0, rd, er, lat);
        n_checks++;
        if (er !== 1'b0 || rd !== 64'h1122334455667788 || lat != 3)
            $display("FAIL load_d got err=%b rdata=%h lat=%0d required 0 1122334455667788 3", er, rd, lat);
        else n_pass++;
        do_txn(1'b0, 64'h8000_000F, 64'd0, 8'h00, 2'd0, 1'b0, rd, er, lat);
        n_checks++;
        if (er !== 1'b0 || rd !== 64'h11)
            $display("FAIL load_b_top got err=%b rdata=%h required 0 11", er, rd);
        else n_pass++;
        do_txn(1'b1, 64'h8000_0008, 64'h8000_0000_0000_0000, 8'hFF, 2'd3, 1'b0, rd, er, lat);
        do_txn(1'b0, 64'h8000_000C, 64'd0, 8'h00, 2'd2, 1'b0, rd, er, lat);
        n_checks++;
        if (er !== 1'b0 || rd !== 64'hFFFF_FFFF_8000_0000)
            $display("FAIL load_w_signed got err=%b rdata=%h required 0 ffffffff80000000", er, rd);
        else n_pass++;
        do_txn(1'b0, 64'h8000_000C, 64'd0, 8'h00, 2'd2, 1'b1, rd, er, lat);
        n_checks++;
        if (er !== 1'b0 || rd !== 64'h0000_0000_8000_0000)
            $display("FAIL load_w_unsigned got err=%b rdata=%h required 0 0000000080000000", er, rd);
        else n_pass++;
        do_txn(1'b1, 64'h8000_0008, 64'h1122334455667788, 8'hFF, 2'd3, 1'b0, rd, er, lat);
        do_txn(1'b1, 64'h8000_0008, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, 2'd3, 1'b0, rd, er, lat);
        do_txn(1'b1, 64'h8000_0008, 64'hDEAD_DEAD_DEAD_DEAD, 8'h00, 2'd3, 1'b0, rd, er, lat);
        n_checks++;
        if (er !== 1'b0)
            $display("FAIL store_zero_mask got err=%b required 0", er);
        else n_pass++;
        do_txn(1'b0, 64'h8000_0008, 64'd0, 8'h00, 2'd3, 1'b0, rd, er, lat);
        n_checks++;
        if (er !== 1'b0 || rd !== 64'h11223344_BBBBBBBB)
            $display("FAIL partial_store got err=%b rdata=%h required 0 11223344bbbbbbbb", er, rd);
        else n_pass++;
        do_txn(1'b0, 64'h8000_000A, 64'd0, 8'h00, 2'd1, 1'b0, rd, er, lat);
        n_checks++;
        if (er !== 1'b0 || rd !== 64'hFFFF_FFFF_FFFF_BBBB)
            $display("FAIL load_h_signed got err=%b rdata=%h required 0 ffffffffffffbbbb", er, rd);
        else n_pass++;
    endtask

    task automatic test_errors();
        logic [63:0] rd;
        logic er;
        int lat;
        sel = 0;
        do_txn(1'b0, 64'h8000_0003, 64'd0, 8'h00, 2'd1, 1'b0, rd, er, lat);
        n_checks++;
        if (er !== 1'b1 || rd !== 64'd0 || lat != 3)
            $display("FAIL misaligned_h got err=%b rdata=%h lat=%0d required 1 0 3", er, rd, lat);
        else n_pass++;
        do_txn(1'b1, 64'h8000_0000, 64'hCAFEF00D_12345678, 8'hFF, 2'd3, 1'b0, rd, er, lat);
        do_txn(1'b1, 64'h7FFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'd3, 1'b0, rd, er, lat);
        n_checks++;
        if (er !== 1'b1 || rd !== 64'd0)
            $display("FAIL below_base_store got err=%b rdata=%h required 1 0", er, rd);
        else n_pass++;
        do_txn(1'b0, 64'h8000_0000, 64'd0, 8'h00, 2'd3, 1'b0, rd, er, lat);
        n_checks++;
        if (er !== 1'b0 || rd !== 64'hCAFEF00D_12345678)
            $display("FAIL adjacent_unchanged got err=%b rdata=%h required 0 cafef00d12345678", er, rd);
        else n_pass++;
        do_txn(1'b1, 64'h8000_7FF8, 64'h0123456789ABCDEF, 8'hFF, 2'd3, 1'b0, rd, er, lat);
        do_txn(1'b0, 64'h8000_7FF8, 64'd0, 8'h00, 2'd3, 1'b0, rd, er, lat);
        n_checks++;
        if (er !== 1'b0 || rd !== 64'h0123456789ABCDEF)
            $display("FAIL last_word got err=%b rdata=%h required 0 0123456789abcdef", er, rd);
        else n_pass++;
        do_txn(1'b0, 64'h8000_8000, 64'd0, 8'h00, 2'd3, 1'b0, rd, er, lat);
        n_checks++;
        if (er !== 1'b1 || rd !== 64'd0)
            $display("FAIL past_end got err=%b rdata=%h required 1 0", er, rd);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int guard = 0;
        int n;
        sel = 0;
        @(negedge clk);
        t_wen = 1'b0; t_addr = 64'h8000_0008; t_size = 2'd3; t_uns = 1'b0; t_wmask = 8'h00;
        t_resp_ready = 1'b0;
        t_valid = 1'b1;
        while (!o_req_ready && guard < 50) begin @(negedge clk); guard++; end
        @(posedge clk);
        @(negedge clk);
        t_addr = 64'h8000_0000; t_size = 2'd2;
        guard = 0;
        while (!o_resp_valid && guard < 40) begin @(negedge clk); guard++; end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (o_resp_valid !== 1'b1 || o_resp_rdata !== 64'h11223344_BBBBBBBB || o_req_ready !== 1'b0)
                $display("FAIL bp_hold%0d got vld=%b rdata=%h rdy=%b required 1 11223344bbbbbbbb 0",
                         i, o_resp_valid, o_resp_rdata, o_req_ready);
            else n_pass++;
            @(negedge clk);
        end
        t_resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (o_req_ready !== 1'b1 || o_resp_valid !== 1'b0)
            $display("FAIL bp_release got rdy=%b vld=%b required 1 0", o_req_ready, o_resp_valid);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        t_valid = 1'b0;
        n = 1;
        while (!o_resp_valid && n < 40) begin @(negedge clk); n++; end
        n_checks++;
        if (n != 3 || o_resp_rdata !== 64'h0000_0000_1234_5678 || o_resp_err !== 1'b0)
            $display("FAIL bp_pending got lat=%0d rdata=%h err=%b required 3 12345678 0",
                     n, o_resp_rdata, o_resp_err);
        else n_pass++;
        @(posedge clk);
    endtask

    task automatic test_reset_mid();
        logic [63:0] rd;
        logic er;
        int lat;
        int guard = 0;
        logic stray = 1'b0;
        sel = 0;
        @(negedge clk);
        t_wen = 1'b1; t_addr = 64'h8000_0020; t_wdata = 64'h5A5A_0F0F_3C3C_9696; t_wmask = 8'hFF;
        t_size = 2'd3; t_resp_ready = 1'b1; t_valid = 1'b1;
        while (!o_req_ready && guard < 50) begin @(negedge clk); guard++; end
        @(posedge clk);
        @(negedge clk);
        t_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (o_resp_valid !== 1'b0 || o_req_ready !== 1'b0)
            $display("FAIL rst_in_wait got vld=%b rdy=%b required 0 0", o_resp_valid, o_req_ready);
        else n_pass++;
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (o_resp_valid) stray = 1'b1;
        end
        n_checks++;
        if (stray !== 1'b0 || o_req_ready !== 1'b1)
            $display("FAIL rst_no_stray got stray=%b rdy=%b required 0 1", stray, o_req_ready);
        else n_pass++;
        do_txn(1'b0, 64'h8000_0020, 64'd0, 8'h00, 2'd3, 1'b0, rd, er, lat);
        n_checks++;
        if (er !== 1'b0 || rd !== 64'h5A5A_0F0F_3C3C_9696)
            $display("FAIL rst_store_kept got err=%b rdata=%h required 0 5a5a0f0f3c3c9696", er, rd);
        else n_pass++;

        sel = 1;
        do_txn(1'b1, 64'h8000_0028, 64'h0102_0304_0506_0708, 8'hFF, 2'd3, 1'b0, rd, er, lat);
        n_checks++;
        if (er !== 1'b0 || lat != 1)
            $display("FAIL lat0_store got err=%b lat=%0d required 0 1", er, lat);
        else n_pass++;
        do_txn(1'b0, 64'h8000_002C, 64'd0, 8'h00, 2'd2, 1'b1, rd, er, lat);
        n_checks++;
        if (er !== 1'b0 || rd !== 64'h0000_0000_0102_0304 || lat != 1)
            $display("FAIL lat0_load got err=%b rdata=%h lat=%0d required 0 01020304 1", er, rd, lat);
        else n_pass++;
        @(negedge clk);
        t_wen = 1'b0; t_addr = 64'h8000_0028; t_size = 2'd3; t_resp_ready = 1'b0; t_valid = 1'b1;
        guard = 0;
        while (!o_req_ready && guard < 50) begin @(negedge clk); guard++; end
        @(posedge clk);
        @(negedge clk);
        t_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        t_resp_ready = 1'b1;
        stray = o_resp_valid;
        repeat (4) begin
            @(negedge clk);
            if (o_resp_valid) stray = 1'b1;
        end
        n_checks++;
        if (stray !== 1'b0 || o_req_ready !== 1'b1)
            $display("FAIL rst_in_resp got stray=%b rdy=%b required 0 1", stray, o_req_ready);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [63:0] rd, erd, addr, wd;
        logic er, eer, wen, uns;
        logic [7:0] wm;
        logic [1:0] sz;
        int lat;
        int kind;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int w = 0; w < 16; w++) begin
                wd = {$urandom, $urandom};
                model_txn(1'b1, REG + 64'(8 * w), wd, 8'hFF, 2'd3, 1'b0, eer, erd);
                do_txn(1'b1, REG + 64'(8 * w), wd, 8'hFF, 2'd3, 1'b0, rd, er, lat);
                n_checks++;
                if (er !== eer || rd !== erd)
                    $display("FAIL rnd_prefill%0d got err=%b rdata=%h required %b %h", w, er, rd, eer, erd);
                else n_pass++;
            end
            for (int t = 0; t < 60; t++) begin
                kind = int'($urandom_range(0, 9));
                if (kind == 0) addr = BASE - 64'd1 - 64'($urandom_range(0, 15));
                else if (kind == 1) addr = BASE + MEMB + 64'($urandom_range(0, 15));
                else addr = REG + 64'($urandom_range(0, 127));
                wen = 1'($urandom_range(0, 2) == 0);
                wd  = {$urandom, $urandom};
                wm  = 8'($urandom);
                sz  = 2'($urandom_range(0, 3));
                uns = 1'($urandom);
                if (!wen && kind > 1) addr = addr & ~((64'd1 << sz) - 64'd1) | 64'($urandom_range(0, 1) & (kind == 2 ? 1 : 0));
                model_txn(wen, addr, wd, wm, sz, uns, eer, erd);
                do_txn(wen, addr, wd, wm, sz, uns, rd, er, lat);
                n_checks++;
                if (er !== eer || rd !== erd || lat != (s == 1 ? 1 : 3))
                    $display("FAIL rnd_s%0d_t%0d wen=%b addr=%h sz=%0d got err=%b rdata=%h lat=%0d required %b %h %0d",
                             s, t, wen, addr, sz, er, rd, lat, eer, erd, (s == 1 ? 1 : 3));
                else n_pass++;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached checks=%0d passed=%0d", n_checks, n_pass);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_store();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
